ch_avg_n: RTL and testbench
===========================

# ch_avg_n

Parametrised complex channel-estimate averager for the post-FFT estimation chain. It accepts up to NUM_IN parallel I/Q estimates per beat and averages a run-time selectable count of them (1..NUM_IN). Power-of-two counts use an exact arithmetic shift; other counts multiply by a rounded reciprocal. The result is rounded and saturated to OUT_W. A 2-stage pipeline with a valid/ready handshake replaces the fixed 2-of-3 / 3-of-3 averager and allows downstream backpressure.

## Interface
- IN_W, 16, input sample width, signed Q1.(IN_W-1)
- OUT_W, 16, output sample width, signed Q1.(OUT_W-1), OUT_W <= IN_W
- NUM_IN, 4, parallel lanes, legal 2..8
- COEF_W, 16, fractional bits of reciprocal constants
- CNT_W, $clog2(NUM_IN+1), derived width of in_cnt
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_i  in  IN_W*NUM_IN  I lanes concatenated, lane 0 in LSBs
- in_q  in  IN_W*NUM_IN  Q lanes, same packing
- in_cnt  in  CNT_W  number of lanes to average, counted from lane 0
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld && in_rdy
- out_i  out  OUT_W  averaged I
- out_q  out  OUT_W  averaged Q
- out_vld  out  1  output valid, held until out_rdy
- out_rdy  in  1  downstream ready
- sat_flag  out  1  sticky saturation flag (present only with macro)
- sat_clr  in  1  synchronous clear of sat_flag (present only with macro)

## Operation
- Lane k is included when k < eff_cnt. eff_cnt is in_cnt clamped to NUM_IN. Excluded lanes contribute 0.
- in_cnt = 0: result is 0 and the beat still flows through the pipeline.
- Stage 1 registers the signed I and Q sums. Sum width is IN_W+$clog2(NUM_IN) (no overflow). eff_cnt is registered alongside.
- Stage 2 scaling:
  - eff_cnt in {1,2,4,8}: sum is arithmetic-shifted right by log2(eff_cnt) at extended precision, COEF_W fractional bits retained.
  - Otherwise: sum × R[eff_cnt], where R[n] = round(2^COEF_W / n), constant table evaluated at elaboration. R[3]=21845, R[5]=13107, R[6]=10923, R[7]=9362 for COEF_W=16.
- Rounding: add half of the output LSB, then arithmetic right shift (round half toward +inf). Drop the extra IN_W-OUT_W input bits the same way.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Overshoot is possible because of reciprocal rounding (e.g. R[6]).
- I and Q are processed identically and in parallel. No cross-coupling.

## Timing
- Reset values: out_i=0, out_q=0, out_vld=0, both stage valids 0, sat_flag=0. in_rdy=1 from the first cycle after reset release.
- Pipeline enable: en = !out_vld || out_rdy. in_rdy = en (combinational path out_rdy -> in_rdy is allowed).
- Latency: 2 cycles. A beat accepted at edge N appears with out_vld=1 after edge N+2 when en stays high. Throughput is 1 beat/cycle.
- When en=0, all stages hold. out_i/out_q/out_vld stay stable until out_rdy.
- Bubbles are not collapsed; an empty stage 1 still requires en to advance.
- Order is preserved. No beat is dropped or duplicated under any in_vld/out_rdy pattern.
- Asserting rst mid-operation clears all valids and outputs immediately; in-flight beats are discarded.

## Configuration
- CH_AVG_SAT_FLAG_EN defined:
  - sat_flag and sat_clr ports exist.
  - sat_flag is set on any clamp of I or Q in a beat leaving stage 2, and stays set until sat_clr=1 at a clock edge or reset.
  - If set and clear occur in the same cycle, set wins.
- Not defined: both ports are absent. Saturation arithmetic is unchanged.

## Test plan
- NUM_IN=4, cnt=3, lanes 0..2 = 0x3000 I/Q, lane 3 = 0x7FFF -> out_i=out_q=0x3000 two cycles later; lane 3 ignored.
- cnt=2, lanes 0x7FFF,0x7FFF -> 0x7FFF (exact shift path). cnt=4, all 0x8000 -> 0x8000. cnt=1, lane0=0x1234 -> 0x1234.
- NUM_IN=8, cnt=6, all 0x7FFF -> 0x7FFF, sat_flag=1. All 0x8000 -> 0x8000, sat_flag=1. sat_clr -> sat_flag=0 next cycle.
- cnt=0 -> 0x0000. cnt=7 with NUM_IN=4 -> treated as 4.
- Continuous in_vld with incrementing data, out_rdy low for 5 cycles mid-stream -> in_rdy low while stalled, outputs held stable, full sequence received in order with no loss.
- rst pulsed low with 2 beats in flight -> out_vld=0 immediately; the first beat after release returns with 2-cycle latency.

Source files
------------

// File: rtl/ch_avg_n.sv
// Complex channel-estimate averager: 2-stage sum/scale pipeline with valid/ready.
// Optional sticky saturation flag enabled by CH_AVG_SAT_FLAG_EN.
module ch_avg_n #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int NUM_IN = 4,
  parameter int COEF_W = 16,
  parameter int CNT_W  = $clog2(NUM_IN+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W*NUM_IN-1:0]   in_i,
  input  logic [IN_W*NUM_IN-1:0]   in_q,
  input  logic [CNT_W-1:0]         in_cnt,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [OUT_W-1:0]         out_i,
  output logic [OUT_W-1:0]         out_q,
  output logic                     out_vld,
`ifdef CH_AVG_SAT_FLAG_EN
  output logic                     sat_flag,
  input  logic                     sat_clr,
`endif
  input  logic                     out_rdy
);

  localparam int SW = IN_W + $clog2(NUM_IN);
  localparam int PW = SW + COEF_W + 2;
  localparam int D  = COEF_W + IN_W - OUT_W;

  localparam logic signed [PW-1:0] MAXV =
    PW'((longint'(1) << (OUT_W-1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - 1;

  function automatic logic [COEF_W:0] recip(input int n);
    longint unsigned num;
    num = (longint'(1) << COEF_W) + longint'(n / 2);
    return (COEF_W+1)'(num / longint'(n));
  endfunction

  function automatic logic signed [PW-1:0] scale(
    input logic signed [SW-1:0] s,
    input logic                 p2,
    input logic [1:0]           sh,
    input logic [COEF_W:0]      r
  );
    logic signed [PW-1:0] x;
    if (p2)
      x = (PW'(s) <<< COEF_W) >>> sh;
    else
      x = PW'(s) * $signed(PW'(r));
    x = x + (PW'(1) <<< (D-1));
    return x >>> D;
  endfunction

  function automatic logic [OUT_W-1:0] clamp(
    input logic signed [PW-1:0] y
  );
    if (y > MAXV)      return MAXV[OUT_W-1:0];
    else if (y < MINV) return MINV[OUT_W-1:0];
    else               return y[OUT_W-1:0];
  endfunction

  logic                    en;
  logic [CNT_W-1:0]        eff;
  logic signed [SW-1:0]    sum_i;
  logic signed [SW-1:0]    sum_q;

  logic                    v1;
  logic [CNT_W-1:0]        c1;
  logic signed [SW-1:0]    s1_i;
  logic signed [SW-1:0]    s1_q;

  logic                    p2;
  logic [1:0]              sh;
  logic [COEF_W:0]         r;
  logic signed [PW-1:0]    y_i;
  logic signed [PW-1:0]    y_q;

  assign en     = !out_vld || out_rdy;
  assign in_rdy = en;

  always_comb begin
    eff   = (in_cnt > CNT_W'(NUM_IN)) ? CNT_W'(NUM_IN) : in_cnt;
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (CNT_W'(k) < eff) begin
        sum_i = sum_i + SW'($signed(in_i[k*IN_W +: IN_W]));
        sum_q = sum_q + SW'($signed(in_q[k*IN_W +: IN_W]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      c1   <= '0;
      s1_i <= '0;
      s1_q <= '0;
    end else if (en) begin
      v1 <= in_vld;
      if (in_vld) begin
        c1   <= eff;
        s1_i <= sum_i;
        s1_q <= sum_q;
      end
    end
  end

  // counts of 0 take the shift path; their sum is already zero
  always_comb begin
    p2 = ((c1 & (c1 - CNT_W'(1))) == '0);
    sh = '0;
    r  = '0;
    for (int b = 1; b < 4; b++) begin
      if (c1 == CNT_W'(1 << b)) sh = 2'(b);
    end
    for (int n = 1; n <= NUM_IN; n++) begin
      if (c1 == CNT_W'(n)) r = recip(n);
    end
    y_i = scale(s1_i, p2, sh, r);
    y_q = scale(s1_q, p2, sh, r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      out_i   <= '0;
      out_q   <= '0;
    end else if (en) begin
      out_vld <= v1;
      if (v1) begin
        out_i <= clamp(y_i);
        out_q <= clamp(y_q);
      end
    end
  end

`ifdef CH_AVG_SAT_FLAG_EN
  logic clip;

  assign clip = (y_i > MAXV) || (y_i < MINV) ||
                (y_q > MAXV) || (y_q < MINV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  sat_flag <= 1'b0;
    else if (en && v1 && clip) sat_flag <= 1'b1;
    else if (sat_clr)          sat_flag <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ch_avg_n.sv
// Directed bench for ch_avg_n: NUM_IN=4 and NUM_IN=8 instances.
// Sat flag checks build only with CH_AVG_SAT_FLAG_EN.
module tb_ch_avg_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0]  i4, q4;
  logic [2:0]   cnt4;
  logic         vld4, rdy4, ord4, ov4;
  logic [15:0]  oi4, oq4;

  logic [127:0] i8, q8;
  logic [3:0]   cnt8;
  logic         vld8, rdy8, ord8, ov8;
  logic [15:0]  oi8, oq8;

`ifdef CH_AVG_SAT_FLAG_EN
  logic sat4, clr4, sat8, clr8;
`endif

  int checks = 0;
  int errors = 0;
  int tx, rx;

  ch_avg_n #(.NUM_IN(4)) u4 (
    .clk(clk), .rst(rst),
    .in_i(i4), .in_q(q4), .in_cnt(cnt4),
    .in_vld(vld4), .in_rdy(rdy4),
    .out_i(oi4), .out_q(oq4), .out_vld(ov4),
`ifdef CH_AVG_SAT_FLAG_EN
    .sat_flag(sat4), .sat_clr(clr4),
`endif
    .out_rdy(ord4)
  );

  ch_avg_n #(.NUM_IN(8)) u8 (
    .clk(clk), .rst(rst),
    .in_i(i8), .in_q(q8), .in_cnt(cnt8),
    .in_vld(vld8), .in_rdy(rdy8),
    .out_i(oi8), .out_q(oq8), .out_vld(ov8),
`ifdef CH_AVG_SAT_FLAG_EN
    .sat_flag(sat8), .sat_clr(clr8),
`endif
    .out_rdy(ord8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] val(input int k);
    return 16'(k * 257 + 3);
  endfunction

  task automatic beat(input bit b8,
                      input logic [3:0] c,
                      input logic [127:0] di,
                      input logic [127:0] dq,
                      input logic [15:0] ei,
                      input logic [15:0] eq,
                      input string tag);
    @(negedge clk);
    if (b8) begin
      cnt8 = c; i8 = di; q8 = dq; vld8 = 1'b1;
    end else begin
      cnt4 = c[2:0]; i4 = di[63:0]; q4 = dq[63:0]; vld4 = 1'b1;
    end
    @(negedge clk);
    vld4 = 1'b0;
    vld8 = 1'b0;
    chk({tag, "_lat1"}, 32'(b8 ? ov8 : ov4), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(b8 ? ov8 : ov4), 32'd1);
    chk({tag, "_i"}, 32'(b8 ? oi8 : oi4), 32'(ei));
    chk({tag, "_q"}, 32'(b8 ? oq8 : oq4), 32'(eq));
  endtask

  initial begin
    rst = 1'b0;
    i4 = '0; q4 = '0; cnt4 = '0; vld4 = 1'b0; ord4 = 1'b1;
    i8 = '0; q8 = '0; cnt8 = '0; vld8 = 1'b0; ord8 = 1'b1;
`ifdef CH_AVG_SAT_FLAG_EN
    clr4 = 1'b0; clr8 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(ov4), 32'd0);
    chk("rst_i", 32'(oi4), 32'd0);
    chk("rst_q", 32'(oq4), 32'd0);
`ifdef CH_AVG_SAT_FLAG_EN
    chk("rst_sat", 32'(sat8), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(rdy4), 32'd1);

    beat(0, 4'd3, 128'h7FFF_3000_3000_3000, 128'h7FFF_3000_3000_3000,
         16'h3000, 16'h3000, "cnt3");
    beat(0, 4'd2, 128'h1111_1111_7FFF_7FFF, 128'h1111_1111_7FFF_7FFF,
         16'h7FFF, 16'h7FFF, "cnt2_max");
    beat(0, 4'd4, {4{16'h8000}}, {4{16'h8000}},
         16'h8000, 16'h8000, "cnt4_min");
    beat(0, 4'd1, 128'h5555_5555_5555_1234, 128'h5555_5555_5555_EDCC,
         16'h1234, 16'hEDCC, "cnt1");
    beat(0, 4'd0, {4{16'h7FFF}}, {4{16'h8000}},
         16'h0000, 16'h0000, "cnt0");
    beat(0, 4'd7, 128'h0400_0300_0200_0100, 128'hFC00_FD00_FE00_FF00,
         16'h0280, 16'hFD80, "cnt7_clamp");
    beat(0, 4'd3, 128'h7FFF_0000_0001_0001, 128'h7FFF_0000_FFFF_FFFF,
         16'h0001, 16'hFFFF, "cnt3_round");
    beat(0, 4'd2, 128'h7FFF_7FFF_0000_0001, 128'h7FFF_7FFF_0000_FFFF,
         16'h0001, 16'h0000, "cnt2_half");

    beat(1, 4'd6, {8{16'h7FFF}}, {8{16'h8000}},
         16'h7FFF, 16'h8000, "n8_cnt6_sat");
`ifdef CH_AVG_SAT_FLAG_EN
    chk("sat_set", 32'(sat8), 32'd1);
    @(negedge clk);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("sat_clr", 32'(sat8), 32'd0);
`endif
    beat(1, 4'd5, {8{16'h1000}}, {8{16'hF000}},
         16'h1000, 16'hF000, "n8_cnt5");
`ifdef CH_AVG_SAT_FLAG_EN
    chk("sat_quiet", 32'(sat8), 32'd0);
`endif
    beat(1, 4'd6, {8{16'h8000}}, {8{16'h0000}},
         16'h8000, 16'h0000, "n8_cnt6_min");
`ifdef CH_AVG_SAT_FLAG_EN
    chk("sat_set_min", 32'(sat8), 32'd1);
`endif

    tx = 0;
    rx = 0;
    cnt4 = 3'd1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      ord4 = !(c >= 8 && c < 13);
      vld4 = (tx < 20);
      i4 = {16'h7FFF, 16'h7FFF, 16'h7FFF, val(tx)};
      q4 = {16'h8000, 16'h8000, 16'h8000, 16'(-val(tx))};
      #1;
      if (!ord4) begin
        chk("stall_rdy", 32'(rdy4), 32'd0);
        chk("stall_vld", 32'(ov4), 32'd1);
        chk("stall_hold", 32'(oi4), 32'(val(rx)));
      end
      if (ov4 && ord4) begin
        chk("stream_i", 32'(oi4), 32'(val(rx)));
        chk("stream_q", 32'(oq4), 32'(16'(-val(rx))));
        rx++;
      end
      if (vld4 && rdy4) tx++;
    end
    vld4 = 1'b0;
    ord4 = 1'b1;
    chk("stream_rx", 32'(rx), 32'd20);
    chk("stream_tx", 32'(tx), 32'd20);

    @(negedge clk);
    cnt4 = 3'd1;
    i4 = 64'h0000_0000_0000_0AAA;
    q4 = 64'h0000_0000_0000_0AAA;
    vld4 = 1'b1;
    @(negedge clk);
    i4 = 64'h0000_0000_0000_0BBB;
    q4 = 64'h0000_0000_0000_0BBB;
    @(negedge clk);
    vld4 = 1'b0;
    chk("pre_rst_vld", 32'(ov4), 32'd1);
    chk("pre_rst_i", 32'(oi4), 32'h0AAA);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(ov4), 32'd0);
    chk("mid_rst_i", 32'(oi4), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_vld", 32'(ov4), 32'd0);
    beat(0, 4'd1, 128'h0000_0000_0000_0CCC, 128'h0000_0000_0000_F334,
         16'h0CCC, 16'hF334, "after_rst");
`ifdef CH_AVG_SAT_FLAG_EN
    chk("sat4_never", 32'(sat4), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
